// File: rtl/miriscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, status/divisor registers and an idle IRQ.
// Optional even parity (8E1) is compiled in with `define MIRISCV_UART_PARITY_EN.
module miriscv_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef MIRISCV_UART_PARITY_EN
  localparam logic PARITY_BIT = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  localparam logic PARITY_BIT = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     period_q, baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q, irq_q;
`ifdef MIRISCV_UART_PARITY_EN
  logic            par_q;
`endif

  logic        hit, wr_en, rd_en;
  logic [1:0]  offset;
  logic        full, empty, push_req, push, pop;
  logic [15:0] frame_period;
  logic [4:0]  count_ext;
  logic        unused_ok;

  assign hit    = data_req_i && (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset = data_addr_i[3:2];
  assign wr_en  = hit && data_we_i;
  assign rd_en  = hit && !data_we_i;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == S_IDLE) && !empty;
  assign push_req = wr_en && (offset == 2'd0) && data_be_i[0];
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign push     = push_req && (!full || pop);

  assign frame_period = (div_q == 16'd0) ? 16'd1 : div_q;
  assign count_ext    = 5'(count_q);
  assign unused_ok    = ^{data_addr_i[1:0], data_wdata_i[31:16], data_be_i[3:2]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (push_req && !push) ovf_d = 1'b1;
    if (wr_en && (offset == 2'd1) && data_be_i[0] && data_wdata_i[3]) ovf_d = 1'b0;
    if (wr_en && (offset == 2'd2)) begin
      if (data_be_i[0]) div_d[7:0]  = data_wdata_i[7:0];
      if (data_be_i[1]) div_d[15:8] = data_wdata_i[15:8];
    end
  end

  always_comb begin
    data_rdata_o = 32'h0;
    if (rd_en) begin
      case (offset)
        2'd1:    data_rdata_o = {16'h0, count_ext[3:0], 3'b000, PARITY_BIT, 4'h0,
                                 ovf_q, empty, full, (state_q != S_IDLE)};
        2'd2:    data_rdata_o = {16'h0, div_q};
        default: data_rdata_o = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  // tx_q/irq_q follow the state one cycle later, so every field stays exactly P cycles on the line.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      period_q <= 16'd0;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b1;
`ifdef MIRISCV_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      irq_q <= (state_q == S_IDLE) && empty;
      case (state_q)
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= shift_q[0];
`ifdef MIRISCV_UART_PARITY_EN
        S_PARITY: tx_q <= par_q;
`endif
        default:  tx_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            period_q <= frame_period;
            baud_q   <= frame_period - 16'd1;
            bit_q    <= 3'd0;
            state_q  <= S_START;
`ifdef MIRISCV_UART_PARITY_EN
            par_q    <= ^mem_q[rd_ptr_q];
`endif
          end
        end
        S_START: begin
          if (baud_q == 16'd0) begin
            baud_q  <= period_q - 16'd1;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_q == 16'd0) begin
            baud_q  <= period_q - 16'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef MIRISCV_UART_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
`ifdef MIRISCV_UART_PARITY_EN
        S_PARITY: begin
          if (baud_q == 16'd0) begin
            baud_q  <= period_q - 16'd1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_q == 16'd0) state_q <= S_IDLE;
          else                 baud_q  <= baud_q - 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_o  = tx_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Bench for miriscv_uart_tx (8N1 build): register map, FIFO overflow, reset abort and
// randomized frames checked against a line-level model of the expected serial waveform.
module tb_miriscv_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        tx, irq;

  int total = 0;
  int bad   = 0;

  logic [7:0] byte_q[$];
  int         per_q[$];

  miriscv_uart_tx dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .data_req_i   (req),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_rdata_o (rdata),
    .tx_o         (tx),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; be = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    req = 1'b0;
  endtask

  function automatic int period_of(input int div);
    return (div == 0) ? 1 : div;
  endfunction

  // Expected line: one idle cycle, then per frame start/8 data LSB-first/stop each P cycles,
  // then one idle-high cycle for the IDLE->START pop. Starts one edge after the first TXDATA write.
  task automatic check_stream();
    logic exp_line[$];
    int   stop_end;
    logic [7:0] b;
    stop_end = 0;
    exp_line.push_back(1'b1);
    for (int f = 0; f < byte_q.size(); f++) begin
      b = byte_q[f];
      for (int i = 0; i < 10; i++) begin
        for (int p = 0; p < per_q[f]; p++) begin
          if (i == 0)      exp_line.push_back(1'b0);
          else if (i == 9) exp_line.push_back(1'b1);
          else             exp_line.push_back(b[i-1]);
        end
      end
      stop_end = exp_line.size();
      exp_line.push_back(1'b1);
    end
    exp_line.push_back(1'b1);
    for (int k = 0; k < exp_line.size(); k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tx[%0d]", k), 32'(tx), 32'(exp_line[k]));
      if (k == stop_end - 1) chk("irq_in_stop", 32'(irq), 32'h0);
      if (k == stop_end)     chk("irq_after_stop", 32'(irq), 32'h1);
    end
    byte_q.delete();
    per_q.delete();
  endtask

  logic [31:0] rd;
  int          d;
  logic [7:0]  b0, b1, b2;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_irq", 32'(irq), 32'h1);
    chk("reset_rdata", rdata, 32'h0);
    bus_read(32'h104, rd); chk("status_reset", rd, 32'h0000_0004);
    bus_read(32'h108, rd); chk("divisor_reset", rd, 32'h0000_0010);
    bus_read(32'h100, rd); chk("txdata_read", rd, 32'h0);
    bus_read(32'h10C, rd); chk("reserved_read", rd, 32'h0);
    bus_read(32'h204, rd); chk("miss_read", rd, 32'h0);

    bus_write(32'h108, 32'h0000_ABCD, 4'b0010);
    bus_read(32'h108, rd); chk("divisor_be1", rd, 32'h0000_AB10);

    // Directed 0x55 at DIVISOR=4, then 0xA3 at DIVISOR=0.
    bus_write(32'h108, 32'd4, 4'b0011);
    bus_write(32'h100, 32'h55, 4'b0001);
    byte_q.push_back(8'h55); per_q.push_back(4);
    check_stream();
    bus_write(32'h108, 32'd0, 4'b0011);
    bus_write(32'h100, 32'hA3, 4'b0001);
    byte_q.push_back(8'hA3); per_q.push_back(1);
    check_stream();

    for (int it = 0; it < 6; it++) begin
      d  = int'($urandom_range(0, 5));
      b0 = 8'($urandom);
      bus_write(32'h108, 32'(d), 4'b0011);
      bus_write(32'h100, {24'h0, b0}, 4'b0001);
      byte_q.push_back(b0); per_q.push_back(period_of(d));
      check_stream();
    end

    // Back-to-back burst through the FIFO.
    d  = int'($urandom_range(1, 3));
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    bus_write(32'h108, 32'(d), 4'b0011);
    bus_write(32'h100, {24'h0, b0}, 4'b0001);
    byte_q.push_back(b0); byte_q.push_back(b1); byte_q.push_back(b2);
    repeat (3) per_q.push_back(period_of(d));
    fork
      check_stream();
      begin
        bus_write(32'h100, {24'h0, b1}, 4'b0001);
        bus_write(32'h100, {24'h0, b2}, 4'b0001);
      end
    join

    // Divisor change mid-frame only affects the next frame.
    b0 = 8'($urandom); b1 = 8'($urandom);
    bus_write(32'h108, 32'd2, 4'b0011);
    bus_write(32'h100, {24'h0, b0}, 4'b0001);
    byte_q.push_back(b0); per_q.push_back(2);
    byte_q.push_back(b1); per_q.push_back(8);
    fork
      check_stream();
      begin
        repeat (4) @(posedge clk);
        bus_write(32'h108, 32'd8, 4'b0011);
        bus_write(32'h100, {24'h0, b1}, 4'b0001);
      end
    join

    // Overflow: A to shifter, B..E fill the FIFO, F dropped.
    bus_write(32'h108, 32'd20, 4'b0011);
    for (int i = 0; i < 6; i++) bus_write(32'h100, 32'(i * 17), 4'b0001);
    bus_read(32'h104, rd); chk("status_overflow", rd, 32'h0000_400B);
    bus_write(32'h104, 32'h7, 4'b0001);
    bus_read(32'h104, rd); chk("status_no_clear", rd, 32'h0000_400B);
    bus_write(32'h104, 32'h8, 4'b0001);
    bus_read(32'h104, rd); chk("status_cleared", rd, 32'h0000_4003);

    // Reset while the frame of byte 0x00 is on the line.
    repeat (20) @(posedge clk);
    #1;
    chk("tx_mid_frame", 32'(tx), 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("tx_after_reset_edge", 32'(tx), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(32'h104, rd); chk("status_after_reset", rd, 32'h0000_0004);
    bus_read(32'h108, rd); chk("divisor_after_reset", rd, 32'h0000_0010);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("tx_idle_after_reset", 32'(tx), 32'h1);
      chk("irq_idle_after_reset", 32'(irq), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
